// File: rtl/security_pkg.sv
// Shared lock-controller types and widths; latency: n/a (declarations only).
// Backpressure: n/a.
package security_pkg;

    localparam int PW_WIDTH    = 16;
    localparam int DIGIT_COUNT = 4;

    typedef enum logic [2:0] {
        LOCKED,
        CHECK,
        UNLOCKED,
        SET_PW,
        LOCKOUT
    } lock_state_t;

    // Wide enough to hold the larger of the two dwell counts; never zero bits.
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// 1-bit rising-edge detector with history reset to 1; combinational rise from registered history.
// Backpressure: none; a level held high yields a single pulse.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic din_q;

    // History resets high so a level already asserted at reset release is not an edge.
    always_ff @(posedge clk) begin
        if (reset) din_q <= 1'b1;
        else       din_q <= din;
    end

    assign rise = din & ~din_q;

endmodule

// File: rtl/lock_controller.sv
// Password lock FSM with attempt counting, lockout alarm and password change; verdict 2 edges after enter.
// Backpressure: none; key edges outside the states that use them are dropped.
module lock_controller
    import security_pkg::*;
#(
    parameter logic [PW_WIDTH-1:0] DEFAULT_PASSWORD = 16'h1234,
    parameter int                  MAX_ATTEMPTS     = 3,
    parameter int                  UNLOCK_CYCLES    = 500,
    parameter int                  LOCKOUT_CYCLES   = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PW_WIDTH-1:0] digits,
    input  logic                storageFull,
    input  logic                enter,
    input  logic                newPassword,
    output logic                unlocked,
    output logic                alarm,
    output logic [3:0]          attemptsLeft,
    output logic                badAttempt,
    output logic                pwUpdated,
    output logic                clearEntry
);

    localparam int         TW        = timer_width(UNLOCK_CYCLES, LOCKOUT_CYCLES);
    localparam logic [3:0] MAX_CNT   = 4'(MAX_ATTEMPTS);
    localparam logic [TW-1:0] UNLOCK_LAST  = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0] LOCKOUT_LAST = TW'(LOCKOUT_CYCLES - 1);

    lock_state_t         state, state_nxt;
    logic [PW_WIDTH-1:0] password, password_nxt;
    logic [PW_WIDTH-1:0] lat_digits, lat_digits_nxt;
    logic                lat_full, lat_full_nxt;
    logic [3:0]          fail_count, fail_count_nxt, fail_inc;
    logic [TW-1:0]       timer, timer_nxt;
    logic                timer_run;
    logic                bad_nxt, upd_nxt, clr_nxt;
    logic                ent_rise, np_rise;

    rise_detect u_ent_rise (
        .clk   (clk),
        .reset (reset),
        .din   (enter),
        .rise  (ent_rise)
    );

    rise_detect u_np_rise (
        .clk   (clk),
        .reset (reset),
        .din   (newPassword),
        .rise  (np_rise)
    );

    assign fail_inc = fail_count + 4'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= LOCKED;
            password   <= DEFAULT_PASSWORD;
            lat_digits <= '0;
            lat_full   <= 1'b0;
            fail_count <= 4'd0;
            timer      <= '0;
            badAttempt <= 1'b0;
            pwUpdated  <= 1'b0;
            clearEntry <= 1'b0;
        end else begin
            state      <= state_nxt;
            password   <= password_nxt;
            lat_digits <= lat_digits_nxt;
            lat_full   <= lat_full_nxt;
            fail_count <= fail_count_nxt;
            timer      <= timer_nxt;
            badAttempt <= bad_nxt;
            pwUpdated  <= upd_nxt;
            clearEntry <= clr_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        password_nxt   = password;
        lat_digits_nxt = lat_digits;
        lat_full_nxt   = lat_full;
        fail_count_nxt = fail_count;
        timer_run      = 1'b0;
        bad_nxt        = 1'b0;
        upd_nxt        = 1'b0;
        clr_nxt        = 1'b0;

        case (state)
            LOCKED: begin
                if (ent_rise) begin
                    lat_digits_nxt = digits;
                    lat_full_nxt   = storageFull;
                    clr_nxt        = 1'b1;
                    state_nxt      = CHECK;
                end
            end
            CHECK: begin
                if (lat_full && (lat_digits == password)) begin
                    fail_count_nxt = 4'd0;
                    state_nxt      = UNLOCKED;
                end else begin
                    bad_nxt        = 1'b1;
                    fail_count_nxt = fail_inc;
                    state_nxt      = (fail_inc == MAX_CNT) ? LOCKOUT : LOCKED;
                end
            end
            UNLOCKED: begin
                timer_run = 1'b1;
                // Enter wins over newPassword when both rise together.
                if (ent_rise) begin
                    clr_nxt   = 1'b1;
                    state_nxt = LOCKED;
                end else if (np_rise) begin
                    clr_nxt   = 1'b1;
                    state_nxt = SET_PW;
                end else if (timer == UNLOCK_LAST) begin
                    state_nxt = LOCKED;
                end
            end
            SET_PW: begin
                timer_run = 1'b1;
                if (ent_rise) begin
                    clr_nxt   = 1'b1;
                    state_nxt = LOCKED;
                    if (storageFull) begin
                        password_nxt = digits;
                        upd_nxt      = 1'b1;
                    end
                end else if (timer == UNLOCK_LAST) begin
                    state_nxt = LOCKED;
                end
            end
            LOCKOUT: begin
                timer_run = 1'b1;
                if (timer == LOCKOUT_LAST) begin
                    fail_count_nxt = 4'd0;
                    state_nxt      = LOCKED;
                end
            end
            default: state_nxt = LOCKED;
        endcase

        timer_nxt = ((state_nxt != state) || !timer_run) ? '0 : timer + 1'b1;
    end

    assign unlocked     = (state == UNLOCKED) || (state == SET_PW);
    assign alarm        = (state == LOCKOUT);
    assign attemptsLeft = MAX_CNT - fail_count;

endmodule

// File: tb/tb_lock_controller.sv
// Directed-vector bench for lock_controller with short timers (unlock 10, lockout 20, 3 attempts).
module tb_lock_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] digits;
    logic        storageFull;
    logic        enter;
    logic        newPassword;
    logic        unlocked;
    logic        alarm;
    logic [3:0]  attemptsLeft;
    logic        badAttempt;
    logic        pwUpdated;
    logic        clearEntry;

    int errors = 0;
    int checks = 0;

    lock_controller #(
        .DEFAULT_PASSWORD (16'h1234),
        .MAX_ATTEMPTS     (3),
        .UNLOCK_CYCLES    (10),
        .LOCKOUT_CYCLES   (20)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .digits       (digits),
        .storageFull  (storageFull),
        .enter        (enter),
        .newPassword  (newPassword),
        .unlocked     (unlocked),
        .alarm        (alarm),
        .attemptsLeft (attemptsLeft),
        .badAttempt   (badAttempt),
        .pwUpdated    (pwUpdated),
        .clearEntry   (clearEntry)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One enter edge, then release; afterwards the CHECK verdict is visible.
    task automatic press_enter();
        enter = 1'b1;
        step();
        enter = 1'b0;
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_unlocked"}, 32'(unlocked), 32'd0);
        check({tag, "_alarm"},    32'(alarm),    32'd0);
        check({tag, "_attempts"}, 32'(attemptsLeft), 32'd3);
        check({tag, "_bad"},      32'(badAttempt), 32'd0);
        check({tag, "_upd"},      32'(pwUpdated),  32'd0);
        check({tag, "_clr"},      32'(clearEntry), 32'd0);
    endtask

    initial begin
        int cnt;
        reset       = 1'b1;
        digits      = 16'h0000;
        storageFull = 1'b0;
        enter       = 1'b0;
        newPassword = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        check_reset_outputs("rst");

        // Held enter: one CHECK, verdict two edges after first sample.
        digits      = 16'h1234;
        storageFull = 1'b1;
        enter       = 1'b1;
        step();
        check("t1_clr_pulse", 32'(clearEntry), 32'd1);
        check("t1_not_yet_unl", 32'(unlocked), 32'd0);
        step();
        check("t1_unlocked", 32'(unlocked), 32'd1);
        check("t1_clr_drop", 32'(clearEntry), 32'd0);
        cnt = 0;
        for (int i = 1; i <= 9; i++) begin
            if (i == 4) enter = 1'b0;
            step();
            if (unlocked !== 1'b1 || clearEntry !== 1'b0 || badAttempt !== 1'b0) cnt++;
        end
        check("t2_unlock_window", 32'(cnt), 32'd0);
        step();
        check("t2_relock_at_10", 32'(unlocked), 32'd0);

        // Three failures, lockout, keys ignored during alarm.
        digits = 16'h9999;
        press_enter();
        check("t3_bad1", 32'(badAttempt), 32'd1);
        check("t3_left2", 32'(attemptsLeft), 32'd2);
        press_enter();
        check("t3_bad2", 32'(badAttempt), 32'd1);
        check("t3_left1", 32'(attemptsLeft), 32'd1);
        press_enter();
        check("t3_bad3", 32'(badAttempt), 32'd1);
        check("t3_left0", 32'(attemptsLeft), 32'd0);
        check("t3_alarm", 32'(alarm), 32'd1);
        digits = 16'h1234;
        cnt = 0;
        for (int i = 1; i <= 19; i++) begin
            enter = (i < 19) ? 1'(i % 2) : 1'b0;
            step();
            if (alarm !== 1'b1 || unlocked !== 1'b0 || clearEntry !== 1'b0) cnt++;
        end
        check("t3_alarm_window", 32'(cnt), 32'd0);
        step();
        check("t3_alarm_drop", 32'(alarm), 32'd0);
        check("t3_left_restore", 32'(attemptsLeft), 32'd3);

        // Password change, then old fails and new succeeds.
        press_enter();
        check("t4_unlocked", 32'(unlocked), 32'd1);
        newPassword = 1'b1;
        step();
        newPassword = 1'b0;
        check("t4_setpw_clr", 32'(clearEntry), 32'd1);
        check("t4_setpw_unl", 32'(unlocked), 32'd1);
        digits = 16'h4321;
        enter  = 1'b1;
        step();
        enter = 1'b0;
        check("t4_pw_upd", 32'(pwUpdated), 32'd1);
        check("t4_pw_clr", 32'(clearEntry), 32'd1);
        check("t4_locked", 32'(unlocked), 32'd0);
        step();
        check("t4_upd_drop", 32'(pwUpdated), 32'd0);
        digits = 16'h1234;
        press_enter();
        check("t4_old_bad", 32'(badAttempt), 32'd1);
        check("t4_old_left", 32'(attemptsLeft), 32'd2);
        digits = 16'h4321;
        press_enter();
        check("t4_new_unl", 32'(unlocked), 32'd1);
        check("t4_new_left", 32'(attemptsLeft), 32'd3);
        press_enter();
        check("t4_manual_relock", 32'(unlocked), 32'd0);

        // Partial entry counts as failure; simultaneous edges relock.
        storageFull = 1'b0;
        press_enter();
        check("t5_partial_bad", 32'(badAttempt), 32'd1);
        check("t5_partial_left", 32'(attemptsLeft), 32'd2);
        storageFull = 1'b1;
        press_enter();
        check("t5_unl", 32'(unlocked), 32'd1);
        enter       = 1'b1;
        newPassword = 1'b1;
        step();
        enter       = 1'b0;
        newPassword = 1'b0;
        check("t5_both_relock", 32'(unlocked), 32'd0);
        check("t5_both_clr", 32'(clearEntry), 32'd1);
        step();
        check("t5_no_setpw", 32'(unlocked), 32'd0);

        // Reset during lockout with enter held across release.
        digits = 16'h9999;
        press_enter();
        press_enter();
        press_enter();
        check("t6_lockout", 32'(alarm), 32'd1);
        step();
        enter = 1'b1;
        reset = 1'b1;
        step();
        check_reset_outputs("t6_in_rst");
        step();
        reset = 1'b0;
        step();
        check_reset_outputs("t6_rel");
        step();
        check("t6_no_check_bad", 32'(badAttempt), 32'd0);
        check("t6_no_check_unl", 32'(unlocked), 32'd0);
        enter  = 1'b0;
        step();
        digits = 16'h1234;
        press_enter();
        check("t6_default_pw", 32'(unlocked), 32'd1);

        // Reset during SET_PW with enter held across release.
        newPassword = 1'b1;
        step();
        newPassword = 1'b0;
        check("t7_setpw", 32'(unlocked), 32'd1);
        digits = 16'h5555;
        enter  = 1'b1;
        reset  = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        check_reset_outputs("t7_rel");
        step();
        check("t7_no_check_bad", 32'(badAttempt), 32'd0);
        check("t7_no_check_unl", 32'(unlocked), 32'd0);
        enter  = 1'b0;
        step();
        digits = 16'h1234;
        press_enter();
        check("t7_pw_kept", 32'(unlocked), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
